// File: rtl/kw8_clock.sv
// kw8_clock: programmable interval clock for a PDP-8 style I/O bus.
// A prescaler divides the system clock down to a tick. Each tick advances
// count toward rate. When count reaches the interval, flag is raised, and
// with ie set this raises intreq. IOT functions on device SELECT load the
// rate, read the count, test/clear the flag and enable/disable interrupts.
// Bus handshake: a cycle is ours when iord or iowr is high and ax[3:8]
// matches SELECT. The response outputs (ioskip, ioc0, ioc1, dx) are
// combinational within that cycle. Register updates land on the rising
// clock edge that ends the cycle.
module kw8_clock #(
    parameter int unsigned SYSTEM_CLOCK = 50000000,
    parameter int unsigned TICK_HZ      = 1000,
    parameter logic [5:0]  SELECT       = 6'o13
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [0:11] ax,
    inout  wire  [0:11] dx,
    input  logic        iowr,
    input  logic        iord,
    input  logic        ioclr,
    output logic        ioskip,
    output logic        ioc0,
    output logic        ioc1,
    output logic        intreq
);

    localparam int unsigned PRESCALE = (SYSTEM_CLOCK / TICK_HZ > 0) ? SYSTEM_CLOCK / TICK_HZ : 1;
    localparam int          PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [2:0] F_CLEI = 3'd1;
    localparam logic [2:0] F_CLDI = 3'd2;
    localparam logic [2:0] F_CLSK = 3'd3;
    localparam logic [2:0] F_CLLR = 3'd4;
    localparam logic [2:0] F_CLRD = 3'd6;

    logic [PW-1:0] presc;
    logic [11:0]   rate;
    logic [11:0]   count;
    logic          flag;
    logic          ie;

    logic [2:0] fn;
    logic       sel;
    logic       tick;
    logic       overflow;
    logic       do_clei;
    logic       do_cldi;
    logic       do_clsk;
    logic       do_cllr;
    logic       do_clrd;

    // The IOT opcode field is not part of device selection.
    logic unused_opcode;
    assign unused_opcode = &{1'b0, ax[0:2]};

    // Decode the current bus cycle; ioclr blocks every IOT side effect.
    always_comb begin
        sel      = (iord | iowr) && (ax[3:8] == SELECT);
        fn       = ax[9:11];
        tick     = (presc == PRE_LAST);
        overflow = tick && (rate != 12'd0) && (count == rate - 12'd1);
        do_clei  = sel && iowr && !ioclr && (fn == F_CLEI);
        do_cldi  = sel && iowr && !ioclr && (fn == F_CLDI);
        do_clsk  = sel && iowr && !ioclr && (fn == F_CLSK);
        do_cllr  = sel && iowr && !ioclr && (fn == F_CLLR);
        do_clrd  = sel && iord && (fn == F_CLRD);
    end

    // Bus responses, forced quiet while reset is held.
    always_comb begin
        ioskip = reset_n && sel && (fn == F_CLSK) && flag;
        ioc0   = reset_n && sel && (((fn == F_CLLR) && iowr) || ((fn == F_CLRD) && iord));
        ioc1   = reset_n && do_clrd;
        intreq = flag & ie;
    end

    assign dx = (reset_n && do_clrd) ? count : {12{1'bz}};

    // Prescaler, interval counter and rate register; CLLR restarts the interval.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            count <= 12'd0;
            rate  <= 12'd0;
        end else if (do_cllr) begin
            presc <= '0;
            count <= 12'd0;
            rate  <= dx;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (rate == 12'd0) begin
                count <= 12'd0;
            end else if (tick) begin
                count <= overflow ? 12'd0 : count + 12'd1;
            end
        end
    end

    // Flag and interrupt enable. A new overflow beats a CLSK clear in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flag <= 1'b0;
            ie   <= 1'b0;
        end else if (ioclr) begin
            flag <= 1'b0;
            ie   <= 1'b0;
        end else begin
            if (overflow && !do_cllr) begin
                flag <= 1'b1;
            end else if (do_clsk) begin
                flag <= 1'b0;
            end
            if (do_clei) begin
                ie <= 1'b1;
            end else if (do_cldi) begin
                ie <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kw8_clock.sv
// Bench for kw8_clock with a 10-clock tick. The reference model describes
// the clock in terms of elapsed clock edges since the last load or reset.
// From that it derives the expected count and flag events with division
// and modulo arithmetic.
module tb_kw8_clock;

    localparam int         P   = 10;
    localparam logic [5:0] SEL = 6'o13;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [0:11] ax      = '0;
    logic        iowr    = 1'b0;
    logic        iord    = 1'b0;
    logic        ioclr   = 1'b0;
    logic [0:11] dx_drv  = '0;
    logic        dx_en   = 1'b0;
    tri1  [0:11] dx;
    wire         ioskip;
    wire         ioc0;
    wire         ioc1;
    wire         intreq;

    assign dx = dx_en ? dx_drv : {12{1'bz}};

    kw8_clock #(
        .SYSTEM_CLOCK(1000),
        .TICK_HZ     (100),
        .SELECT      (SEL)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .ax     (ax),
        .dx     (dx),
        .iowr   (iowr),
        .iord   (iord),
        .ioclr  (ioclr),
        .ioskip (ioskip),
        .ioc0   (ioc0),
        .ioc1   (ioc1),
        .intreq (intreq)
    );

    always #5 clock = ~clock;

    // Reference model state
    int m_rate   = 0;
    int m_flag   = 0;
    int m_ie     = 0;
    int cyc      = 0;
    int load_cyc = 0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    function automatic int m_count();
        if (m_rate == 0) return 0;
        return ((cyc - load_cyc) / P) % m_rate;
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
        end
    endtask

    // Advance the model across one rising edge with the given bus inputs.
    task automatic model_edge(input logic wr, input logic rd, input logic clr,
                              input logic [2:0] f, input logic hit, input logic [11:0] data);
        int  k1;
        bit  ovf;
        bit  sel;
        sel = hit && (wr || rd);
        k1  = cyc - load_cyc + 1;
        ovf = (m_rate != 0) && (k1 % P == 0) && (((k1 / P) % m_rate) == 0);
        if (clr) begin
            m_flag = 0;
            m_ie   = 0;
        end else if (sel && wr && f == 3'd4) begin
            m_rate   = int'(data);
            load_cyc = cyc + 1;
        end else begin
            if (ovf) m_flag = 1;
            else if (sel && wr && f == 3'd3) m_flag = 0;
            if (sel && wr && f == 3'd1) m_ie = 1;
            if (sel && wr && f == 3'd2) m_ie = 0;
        end
        cyc++;
    endtask

    // One bus cycle: drive at the falling edge, check responses, model the next rising edge.
    task automatic step(input logic wr, input logic rd, input logic clr,
                        input logic [2:0] f, input logic hit, input logic [11:0] data);
        logic        drd;
        logic        sel;
        logic [11:0] e_dx;
        @(negedge clock);
        ax     = {3'o6, (hit ? SEL : ~SEL), f};
        iowr   = wr;
        iord   = rd;
        ioclr  = clr;
        sel    = hit && (wr || rd);
        drd    = sel && rd && (f == 3'd6);
        dx_en  = wr && !drd;
        dx_drv = data;
        #1;
        e_dx = drd ? 12'(m_count()) : (dx_en ? data : 12'o7777);
        check("ioskip", 12'(ioskip), 12'(sel && f == 3'd3 && m_flag != 0));
        check("ioc0",   12'(ioc0),   12'(sel && ((f == 3'd4 && wr) || (f == 3'd6 && rd))));
        check("ioc1",   12'(ioc1),   12'(drd));
        check("dx",     dx,          e_dx);
        check("intreq", 12'(intreq), 12'(m_flag != 0 && m_ie != 0));
        model_edge(wr, rd, clr, f, hit, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 12'd0);
    endtask

    // Read-only CLSK: exposes flag through ioskip without clearing it.
    task automatic peek(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 12'd0);
    endtask

    task automatic iot_wr(input logic [2:0] f, input logic [11:0] data);
        step(1'b1, 1'b0, 1'b0, f, 1'b1, data);
    endtask

    // Pulse reset mid-cycle with a CLRD presented; everything must go quiet at once.
    task automatic do_reset();
        @(negedge clock);
        ax     = {3'o6, SEL, 3'd6};
        iord   = 1'b1;
        iowr   = 1'b0;
        ioclr  = 1'b0;
        dx_en  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_ioskip", 12'(ioskip), 12'd0);
        check("rst_ioc0",   12'(ioc0),   12'd0);
        check("rst_ioc1",   12'(ioc1),   12'd0);
        check("rst_dx",     dx,          12'o7777);
        check("rst_intreq", 12'(intreq), 12'd0);
        @(negedge clock);
        ax      = '0;
        iord    = 1'b0;
        reset_n = 1'b1;
        m_rate   = 0;
        m_flag   = 0;
        m_ie     = 0;
        load_cyc = cyc;
        model_edge(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 12'd0);
    endtask

    initial begin
        int          r;
        logic [2:0]  f;
        logic        wr;
        logic        rd;
        logic        hit;
        logic [11:0] data;

        // Power-on reset
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n  = 1'b1;
        load_cyc = cyc;
        model_edge(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 12'd0);
        peek(2);

        // Load rate 3: ioc0 during CLLR, flag after 30 clocks, no interrupt
        iot_wr(3'd4, 12'o0003);
        peek(32);

        // Enable interrupts, rate 2, CLSK clears, second CLSK misses
        iot_wr(3'd1, 12'd0);
        iot_wr(3'd4, 12'o0002);
        idle(22);
        iot_wr(3'd3, 12'd0);
        idle(1);
        iot_wr(3'd3, 12'd0);
        iot_wr(3'd2, 12'd0);

        // Rate 1 with CLSK landing exactly on an overflow edge
        iot_wr(3'd4, 12'o0001);
        idle(19);
        iot_wr(3'd3, 12'd0);
        peek(3);

        // Rate 5: CLRD after three ticks, other reads leave dx floating
        iot_wr(3'd3, 12'd0);
        iot_wr(3'd4, 12'o0005);
        idle(30);
        step(1'b0, 1'b1, 1'b0, 3'd6, 1'b1, 12'd0);
        step(1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 12'd0);
        step(1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 12'd0);
        peek(2);

        // ioclr with flag and ie set, then flag returns after the interval
        iot_wr(3'd1, 12'd0);
        iot_wr(3'd4, 12'o0002);
        idle(21);
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 12'd0);
        peek(25);

        // Reset mid-count with an interrupt pending, then a long quiet stretch
        iot_wr(3'd1, 12'd0);
        iot_wr(3'd4, 12'o0002);
        idle(25);
        do_reset();
        peek(120);
        iot_wr(3'd4, 12'o0001);
        peek(12);

        // Randomized bus traffic
        for (int n = 0; n < 900; n++) begin
            r = $urandom_range(0, 299);
            if (r == 0) begin
                do_reset();
            end else if (r < 8) begin
                step(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'b0, 12'd0);
            end else if (r < 25) begin
                iot_wr(3'd4, 12'($urandom_range(0, 4)));
            end else if (r < 130) begin
                f    = 3'($urandom_range(0, 7));
                hit  = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 2))
                    0: begin wr = 1'b1; rd = 1'b0; end
                    1: begin wr = 1'b0; rd = 1'b1; end
                    default: begin wr = 1'b1; rd = 1'b1; end
                endcase
                data = (f == 3'd4) ? 12'($urandom_range(0, 6)) : 12'($urandom_range(0, 4095));
                step(wr, rd, 1'b0, f, hit, data);
            end else begin
                idle(1);
            end
        end

        @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
